fir_mac_param: RTL
==================

Name: fir_mac_param

Overview:
- Parametrised single-MAC serial FIR filter, successor to the fixed 21-tap, 18-bit FIR.
- Accepts one sample per handshake and shifts it into a TAPS-deep delay line.
- Accumulates TAPS products over TAPS cycles, then emits one scaled output with a valid pulse.
- Coefficients are held in a run-time writable register file, not a constant ROM; sits between the sample source (ADC/UART front end) and the output stage.

Parameters:
- DW, 18: sample and output width, signed two's complement.
- CW, 18: coefficient width, signed.
- TAPS, 21: number of taps, minimum 2.
- OUT_SHIFT, 17: arithmetic right shift applied to the accumulator before output truncation.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, synchronous, active-low.
- in_valid_i, in, 1: sample xn_i is valid.
- in_ready_o, out, 1: block can accept a sample.
- xn_i, in, DW: input sample.
- coef_we_i, in, 1: coefficient write strobe.
- coef_addr_i, in, clog2(TAPS): coefficient index.
- coef_data_i, in, CW: coefficient value.
- y_o, out, DW: filter output.
- y_valid_o, out, 1: one-cycle pulse, y_o is new.
- y_sat_o, out, 1: output was clamped (see Optional Feature).

Behaviour:
- Accumulator width: ACC_W = DW + CW + clog2(TAPS), signed; products are full DW+CW bits, sign-extended before accumulation. No accumulator overflow is possible.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o (accept edge): x[0] <= xn_i, x[k] <= x[k-1], acc <= 0, i <= 0, go to MAC.
- MAC:
  - in_ready_o = 0.
  - Each edge: acc <= acc + x[i]*a[i]; i <= i+1.
  - After the edge with i = TAPS-1, go to DONE. Exactly TAPS MAC edges.
- DONE:
  - y_o <= (acc >>> OUT_SHIFT) truncated to the low DW bits.
  - y_valid_o = 1 for exactly that one cycle.
  - Next edge returns to IDLE.
- Latency: y_valid_o rises TAPS+1 edges after the accept edge.
- Throughput: one sample per TAPS+2 cycles when in_valid_i is held high.
- y_o holds its value until the next DONE.
- Coefficient writes:
  - Take effect on the edge only in IDLE.
  - Silently dropped in MAC or DONE, so a computation never sees mixed coefficients.
  - Writes with coef_addr_i >= TAPS are ignored.
  - A write and a sample accept on the same IDLE edge are both performed; the new coefficient is used by that computation.
- Delay line shifts only on accept; samples are never lost or duplicated.
- Reset (rst_i = 0 at an edge, any state, including mid-MAC):
  - State <= IDLE; x[*], a[*], acc, i <= 0.
  - y_o <= 0; y_valid_o <= 0; y_sat_o <= 0.
  - An in-flight result is discarded and no y_valid_o is produced.
- in_ready_o is low during reset and high on the first cycle after rst_i returns high.

Optional Feature:
- Macro: FIR_MAC_PARAM_SAT_EN.
- Defined: in DONE, if the shifted accumulator exceeds the DW-bit signed range, y_o clamps to 2^(DW-1)-1 or -2^(DW-1), and y_sat_o = 1 for the same cycle as y_valid_o.
- Undefined: y_o is plain truncation (wrap-around); y_sat_o is tied 0.

Decomposition:
- Package fir_pkg:
  - state enum {IDLE, MAC, DONE};
  - a clog2 function;
  - ACC_W derivation helper;
  - saturation helper function.
- One sub-module: fir_delay_line, parameters DW and TAPS, with an enable input and a sample-select output (x[i] mux), replacing the per-register instances plus separate mux.
- The coefficient register file and the MAC datapath stay in the top module.

Test Plan:
- Impulse response:
  - Set OUT_SHIFT=17 and write a[k] = 2*(k+1) for k = 0..20.
  - Send xn = 0x10000, then 21 zeros.
  - The 22 outputs must read 1, 2, ... 21, 0.
  - Each y_valid_o comes exactly 22 edges after its accept.
- Handshake:
  - Hold in_valid_i = 1 for 5 samples.
  - Accepts must occur every 23 cycles.
  - in_ready_o must be 0 throughout MAC/DONE.
  - There must be exactly 5 y_valid_o pulses.
- Coefficient write while busy:
  - Write a[0] = 0x1FFFF during MAC.
  - The current and next outputs must use the old a[0].
  - A write in IDLE must be used on the following sample.
  - A write with coef_addr_i = 25 must change nothing.
- Reset mid-MAC:
  - Drive rst_i = 0 on MAC cycle 10.
  - Required: no y_valid_o, y_o = 0, in_ready_o = 1 one cycle after release.
  - Delay line and coefficients must read zero (first output after reset is 0).
- Saturation:
  - Set all a[k] = 0x1FFFF and xn = 0x1FFFF repeated 21 times.
  - With FIR_MAC_PARAM_SAT_EN: y_o = 0x1FFFF and y_sat_o = 1.
  - Without the macro: y_o equals the truncated low 18 bits and y_sat_o = 0.
- Parameter sweep:
  - Run TAPS=2 with DW=8, CW=8, OUT_SHIFT=0, a = {1, -1}, inputs 5, 7.
  - Outputs must be 5, then 2; latency 3 edges.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared state encoding and sizing/saturation helpers for the serial FIR (fir_mac_param).
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Width used by the saturation range check; must cover any accumulator width in use.
  localparam int SAT_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Full-precision products summed TAPS times can never overflow this width.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic logic sat_overflow(input logic signed [SAT_W-1:0] v, input int dw);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register that advances only when enabled, with a tap-select read port.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DW   = 18,
  parameter int TAPS = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DW-1:0]          sample,
  input  logic [clog2(TAPS)-1:0] sel,
  output logic [DW-1:0]          tap
);

  logic [DW-1:0] taps_q [TAPS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
    end else if (en) begin
      taps_q[0] <= sample;
      for (int k = 1; k < TAPS; k++) taps_q[k] <= taps_q[k-1];
    end
  end

  assign tap = taps_q[sel];

endmodule

// File: rtl/fir_mac_param.sv
// Serial single-MAC FIR with a run-time coefficient file; y_valid_o pulses TAPS+1 edges after accept,
// in_ready_o stays low while a result is being computed. Output clamping enabled by FIR_MAC_PARAM_SAT_EN.
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int DW        = 18,
  parameter int CW        = 18,
  parameter int TAPS      = 21,
  parameter int OUT_SHIFT = 17
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DW-1:0]          xn_i,
  input  logic                   coef_we_i,
  input  logic [clog2(TAPS)-1:0] coef_addr_i,
  input  logic [CW-1:0]          coef_data_i,
  output logic [DW-1:0]          y_o,
  output logic                   y_valid_o,
  output logic                   y_sat_o
);

  localparam int AW    = clog2(TAPS);
  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_width(DW, CW, TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t                  state;
  logic [AW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           coef [TAPS];
  logic [DW-1:0]           x_sel;
  logic signed [PW-1:0]    prod;
  logic                    accept;
  logic                    coef_wr;
  logic                    sat;
  logic [DW-1:0]           y_next;

  assign accept = in_valid_i & in_ready_o;
  // Writes outside IDLE are dropped so a running sum never mixes old and new coefficients.
  assign coef_wr = coef_we_i && (state == IDLE) && (32'(coef_addr_i) < TAPS);

  fir_delay_line #(
    .DW   (DW),
    .TAPS (TAPS)
  ) u_delay (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (accept),
    .sample (xn_i),
    .sel    (idx),
    .tap    (x_sel)
  );

  assign prod = PW'($signed(x_sel)) * PW'($signed(coef[idx]));

`ifdef FIR_MAC_PARAM_SAT_EN
  assign sat    = sat_overflow(SAT_W'(acc >>> OUT_SHIFT), DW);
  assign y_next = !sat           ? DW'(acc >>> OUT_SHIFT) :
                  acc[ACC_W-1]   ? {1'b1, {(DW-1){1'b0}}} :
                                   {1'b0, {(DW-1){1'b1}}};
`else
  assign sat    = 1'b0;
  assign y_next = DW'(acc >>> OUT_SHIFT);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_wr) begin
      coef[coef_addr_i] <= coef_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      in_ready_o <= 1'b0;
      y_o        <= '0;
      y_valid_o  <= 1'b0;
      y_sat_o    <= 1'b0;
    end else begin
      y_valid_o <= 1'b0;
      y_sat_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= '0;
            idx        <= '0;
            in_ready_o <= 1'b0;
            state      <= MAC;
          end else begin
            in_ready_o <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          y_o        <= y_next;
          y_valid_o  <= 1'b1;
          y_sat_o    <= sat;
          in_ready_o <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          in_ready_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
